// File: rtl/ctrl_bubble_stage_if.sv
// ctrl_bubble_stage_if: handshake/bus bundle between ID, the ID/EX bubble stage and EX.
// Optional macro CTRL_BUBBLE_STATS_EN adds the bubble_cnt statistics signal.
interface ctrl_bubble_stage_if #(
    parameter int CTRL_W = 32,
    parameter int CNT_W  = 4
);
    logic [CTRL_W-1:0] ctrl_in;
    logic              valid_in;
    logic              stall_req;
    logic              mstall_req;
    logic [CNT_W-1:0]  mstall_len;
    logic              flush;
    logic [CTRL_W-1:0] ctrl_out;
    logic              valid_out;
    logic              stall_out;
    logic              busy;
`ifdef CTRL_BUBBLE_STATS_EN
    logic [15:0]       bubble_cnt;
`endif

    // ID-side driver: supplies decoded controls and hazard requests.
    modport master (
        output ctrl_in, valid_in, stall_req, mstall_req, mstall_len, flush,
`ifdef CTRL_BUBBLE_STATS_EN
        input  bubble_cnt,
`endif
        input  ctrl_out, valid_out, stall_out, busy
    );

    // The bubble stage itself.
    modport slave (
        input  ctrl_in, valid_in, stall_req, mstall_req, mstall_len, flush,
`ifdef CTRL_BUBBLE_STATS_EN
        output bubble_cnt,
`endif
        output ctrl_out, valid_out, stall_out, busy
    );
endinterface

// File: rtl/ctrl_bubble_stage.sv
// ctrl_bubble_stage: ID/EX control-bundle register that inserts bubbles for
// single-cycle stalls, programmable multi-cycle stalls and flushes, and drives
// the hold signal back to PC and IF/ID.
// Optional macro CTRL_BUBBLE_STATS_EN adds a saturating 16-bit bubble counter.
module ctrl_bubble_stage #(
    parameter int                 CTRL_W     = 32,
    parameter int                 CNT_W      = 4,
    parameter logic [CTRL_W-1:0]  BUBBLE_VAL = '0
) (
    input logic                clk,
    input logic                rst_n,
    ctrl_bubble_stage_if.slave bus
);

    typedef enum logic {RUN, HOLD} state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CTRL_W-1:0] ctrlOut_q;
    logic              validOut_q;
    logic              busy_q;

    logic              anyReq;
    logic [CNT_W-1:0]  effLen;
    logic              stallNow;

    // A zero length is treated as a one-cycle stall; the request lines only matter in RUN.
    assign anyReq   = bus.stall_req | bus.mstall_req;
    assign effLen   = (bus.mstall_len == '0) ? CNT_W'(1) : bus.mstall_len;
    assign stallNow = rst_n & ~bus.flush & ((state_q == HOLD) | anyReq);

    assign bus.stall_out = stallNow;
    assign bus.ctrl_out  = ctrlOut_q;
    assign bus.valid_out = validOut_q;
    assign bus.busy      = busy_q;

    // RUN/HOLD controller with registered bundle, valid and busy outputs; flush has top priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            ctrlOut_q  <= BUBBLE_VAL;
            validOut_q <= 1'b0;
            busy_q     <= 1'b0;
        end else if (bus.flush) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            ctrlOut_q  <= BUBBLE_VAL;
            validOut_q <= 1'b0;
            busy_q     <= 1'b0;
        end else if (state_q == HOLD) begin
            ctrlOut_q  <= BUBBLE_VAL;
            validOut_q <= 1'b0;
            cnt_q      <= cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
                state_q <= RUN;
                busy_q  <= 1'b0;
            end
        end else if (anyReq) begin
            ctrlOut_q  <= BUBBLE_VAL;
            validOut_q <= 1'b0;
            if (bus.mstall_req && (effLen > CNT_W'(1))) begin
                cnt_q   <= effLen - CNT_W'(1);
                state_q <= HOLD;
                busy_q  <= 1'b1;
            end
        end else if (bus.valid_in) begin
            ctrlOut_q  <= bus.ctrl_in;
            validOut_q <= 1'b1;
        end else begin
            ctrlOut_q  <= BUBBLE_VAL;
            validOut_q <= 1'b0;
        end
    end

`ifdef CTRL_BUBBLE_STATS_EN
    logic [15:0] bubbleCnt_q;

    assign bus.bubble_cnt = bubbleCnt_q;

    // Count bubbles caused by stall requests or HOLD; every such cycle is exactly a stall_out cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubbleCnt_q <= '0;
        end else if (stallNow && (bubbleCnt_q != 16'hFFFF)) begin
            bubbleCnt_q <= bubbleCnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_bubble_stage.sv
// tb_ctrl_bubble_stage: scoreboard bench for ctrl_bubble_stage with directed
// and random stimulus against a stall-cycle-counting reference model.
// Define CTRL_BUBBLE_STATS_EN to also check bubble_cnt.
module tb_ctrl_bubble_stage;

    localparam int CTRL_W = 32;
    localparam int CNT_W  = 4;

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic              valid;
        logic              busy;
        logic [15:0]       bcnt;
    } exp_t;

    logic clk;
    logic rst_n;

    ctrl_bubble_stage_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

    ctrl_bubble_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W), .BUBBLE_VAL('0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t outQ[$];
    bit   stallQ[$];

    // Model state: stall cycles still owed after the current one, and bubbles counted so far.
    int   remStall  = 0;
    int   expBubble = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [CTRL_W-1:0] act, input logic [CTRL_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and push what the stage must do.
    task automatic applyStimulus(input logic rn, input logic [CTRL_W-1:0] ctrl, input logic vld,
                                 input logic sreq, input logic mreq, input logic [CNT_W-1:0] len,
                                 input logic fl);
        exp_t e;
        bit   st;
        int   n;
        @(negedge clk);
        rst_n          = rn;
        bus.ctrl_in    = ctrl;
        bus.valid_in   = vld;
        bus.stall_req  = sreq;
        bus.mstall_req = mreq;
        bus.mstall_len = len;
        bus.flush      = fl;
        e.ctrl  = '0;
        e.valid = 1'b0;
        st      = 1'b0;
        if (!rn) begin
            remStall  = 0;
            expBubble = 0;
        end else if (fl) begin
            remStall = 0;
        end else if (remStall > 0) begin
            st = 1'b1;
            remStall--;
        end else if (sreq || mreq) begin
            st = 1'b1;
            n  = mreq ? ((int'(len) == 0) ? 1 : int'(len)) : 1;
            remStall = n - 1;
        end else if (vld) begin
            e.ctrl  = ctrl;
            e.valid = 1'b1;
        end
        if (st && expBubble < 65535) expBubble++;
        e.busy = (remStall > 0);
        e.bcnt = 16'(expBubble);
        stallQ.push_back(st);
        outQ.push_back(e);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b1, $urandom, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    // Combinational stall check, mid low phase of the cycle the inputs were applied.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (stallQ.size() > 0) begin
                bit s;
                s = stallQ.pop_front();
                checkOutput("stall_out", {31'd0, bus.stall_out}, {31'd0, s});
            end
        end
    end

    // Registered output check, just after the capturing edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (outQ.size() > 0) begin
                exp_t e;
                e = outQ.pop_front();
                checkOutput("ctrl_out", bus.ctrl_out, e.ctrl);
                checkOutput("valid_out", {31'd0, bus.valid_out}, {31'd0, e.valid});
                checkOutput("busy", {31'd0, bus.busy}, {31'd0, e.busy});
`ifdef CTRL_BUBBLE_STATS_EN
                checkOutput("bubble_cnt", {16'd0, bus.bubble_cnt}, {16'd0, e.bcnt});
`endif
            end
        end
    end

    // Directed test-plan sequences followed by a random soak.
    initial begin
        rst_n          = 1'b0;
        bus.ctrl_in    = '0;
        bus.valid_in   = 1'b0;
        bus.stall_req  = 1'b0;
        bus.mstall_req = 1'b0;
        bus.mstall_len = '0;
        bus.flush      = 1'b0;

        applyStimulus(1'b0, 32'hDEAD, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 32'hBEEF, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0);

        applyStimulus(1'b1, 32'h11, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 32'h22, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 32'h33, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 32'h44, 1'b1, 1'b0, 1'b0, '0, 1'b0);

        applyStimulus(1'b1, 32'hAB, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 32'hAB, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, '0, 1'b0);

        applyStimulus(1'b1, 32'h66, 1'b1, 1'b0, 1'b1, 4'd4, 1'b0);
        applyStimulus(1'b1, 32'h67, 1'b1, 1'b1, 1'b1, 4'd9, 1'b0);
        applyStimulus(1'b1, 32'h68, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 32'h69, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        idle(2);

        applyStimulus(1'b1, 32'h70, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
        applyStimulus(1'b1, 32'h71, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 32'h72, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0);
        applyStimulus(1'b1, 32'h73, 1'b1, 1'b0, 1'b0, '0, 1'b0);

        applyStimulus(1'b1, 32'h80, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 32'h81, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 32'h82, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0);
        applyStimulus(1'b1, 32'h83, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 32'h84, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 32'h85, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 32'h86, 1'b1, 1'b0, 1'b0, '0, 1'b0);

        applyStimulus(1'b1, 32'h90, 1'b1, 1'b0, 1'b1, 4'd15, 1'b0);
        idle(20);
        applyStimulus(1'b1, 32'h91, 1'b1, 1'b0, 1'b1, 4'd15, 1'b0);
        idle(5);
        applyStimulus(1'b0, 32'h92, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        idle(3);

        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 99) != 0), $urandom, ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0),
                          CNT_W'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0));
        end

        @(posedge clk);
        #5;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
